pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the 5-stage ARM core: hazard detection, operand forwarding selection, branch flush and multi-cycle data-memory freeze, in one block. It supersedes the stall-only hazard check with registered forwarding selects for the EXE stage. It also adds a wait-state freeze for slow data memory and a saturating stall-cycle counter. It sits beside the datapath top and drives the enables and flushes of the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/mem_wait_fsm.sv | 58 +++++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_pkg;

  // EXE operand mux selects
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Data-memory wait-state FSM
  typedef enum logic {StIdle, StWait} mw_state_e;

  // The youngest producer (EXE) wins over the older one (MEM)
  function automatic logic [1:0] fwd_select(input logic exe_hit, input logic mem_hit);
    if (exe_hit)      return FWD_MEM;
    else if (mem_hit) return FWD_WB;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Holds the pipeline while a slow data-memory access completes.
module mem_wait_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access,
  output logic freeze
);

  localparam logic            WaitEn = (MEM_WAIT != 0);
  localparam int unsigned     CntW   = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_WAIT);

  mw_state_e       state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  // Next state and freeze; freeze is high for the first MEM_WAIT cycles of an access
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (WaitEn && mem_access) begin
          // a new access is not started while reset is being applied
          freeze  = !rst;
          cnt_d   = CntW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != CntMax) begin
          freeze = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
        end else begin
          // release cycle: MEM completes, pipeline moves
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  // State and counter registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use/RAW hazards, forwarding selects, branch flush, memory freeze.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned FWD_EN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_move,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_access,
  input  logic             exe_branch,
  output logic             freeze,
  output logic             stall,
  output logic             ifid_flush,
  output logic             idexe_flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [15:0]      stall_cycles
);

  localparam logic FwdOn = (FWD_EN != 0);

  logic        use1, use2;
  logic        exe_hit1, exe_hit2, mem_hit1, mem_hit2;
  logic        lu;
  logic [1:0]  sel_a, sel_b;
  logic [1:0]  fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic [15:0] stall_cycles_d, stall_cycles_q;

  mem_wait_fsm #(
    .MEM_WAIT (MEM_WAIT)
  ) u_mem_wait_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_access (mem_access),
    .freeze     (freeze)
  );

  // Operand match terms and hazard detection
  always_comb begin
    use1     = !id_move;
    use2     = id_two_src;
    exe_hit1 = use1 & exe_wb_en & (id_src1 == exe_dest);
    exe_hit2 = use2 & exe_wb_en & (id_src2 == exe_dest);
    mem_hit1 = use1 & mem_wb_en & (id_src1 == mem_dest);
    mem_hit2 = use2 & mem_wb_en & (id_src2 == mem_dest);
    if (FwdOn) begin
      lu    = exe_mem_r_en & (exe_hit1 | exe_hit2);
      sel_a = fwd_select(exe_hit1, mem_hit1);
      sel_b = fwd_select(exe_hit2, mem_hit2);
    end else begin
      lu    = exe_hit1 | exe_hit2 | mem_hit1 | mem_hit2;
      sel_a = FWD_REG;
      sel_b = FWD_REG;
    end
  end

  // Prioritised control: rst > freeze > branch > load-use > normal
  always_comb begin
    stall       = 1'b0;
    ifid_flush  = 1'b0;
    idexe_flush = 1'b0;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    if (rst) begin
      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
    end else if (freeze) begin
      // everything holds, including the selects
    end else if (exe_branch) begin
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
      fwd_a_d     = FWD_REG;
      fwd_b_d     = FWD_REG;
    end else if (lu) begin
      stall       = 1'b1;
      idexe_flush = 1'b1;
      fwd_a_d     = FWD_REG;
      fwd_b_d     = FWD_REG;
    end else begin
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
    end
  end

  // Saturating stall/freeze cycle counter
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall | freeze) && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Registered selects and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q        <= FWD_REG;
      fwd_b_q        <= FWD_REG;
      stall_cycles_q <= '0;
    end else begin
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fwd_sel_a    = fwd_a_q;
  assign fwd_sel_b    = fwd_b_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: three configurations share one stimulus set.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_two_src, id_move, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_access, exe_branch;

  // u_fwd: forwarding, MEM_WAIT=2; u_nof: stall-only, MEM_WAIT=0; u_w3: forwarding, MEM_WAIT=3
  logic        f_freeze, f_stall, f_ifid, f_idexe;
  logic [1:0]  f_fa, f_fb;
  logic [15:0] f_sc;
  logic        n_freeze, n_stall, n_ifid, n_idexe;
  logic [1:0]  n_fa, n_fb;
  logic [15:0] n_sc;
  logic        w_freeze, w_stall, w_ifid, w_idexe;
  logic [1:0]  w_fa, w_fb;
  logic [15:0] w_sc;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_W(4), .MEM_WAIT(2), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_move(id_move), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .exe_branch(exe_branch), .freeze(f_freeze), .stall(f_stall), .ifid_flush(f_ifid),
    .idexe_flush(f_idexe), .fwd_sel_a(f_fa), .fwd_sel_b(f_fb), .stall_cycles(f_sc)
  );

  pipe_ctrl #(.REG_W(4), .MEM_WAIT(0), .FWD_EN(0)) u_nof (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_move(id_move), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .exe_branch(exe_branch), .freeze(n_freeze), .stall(n_stall), .ifid_flush(n_ifid),
    .idexe_flush(n_idexe), .fwd_sel_a(n_fa), .fwd_sel_b(n_fb), .stall_cycles(n_sc)
  );

  pipe_ctrl #(.REG_W(4), .MEM_WAIT(3), .FWD_EN(1)) u_w3 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_move(id_move), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .exe_branch(exe_branch), .freeze(w_freeze), .stall(w_stall), .ifid_flush(w_ifid),
    .idexe_flush(w_idexe), .fwd_sel_a(w_fa), .fwd_sel_b(w_fb), .stall_cycles(w_sc)
  );

  task automatic clear_in();
    id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    id_two_src = 1'b0; id_move = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_wb_en = 1'b0; mem_access = 1'b0; exe_branch = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (f_freeze !== 1'b0) begin n_fail++; $display("FAIL reset.freeze got %0d want 0", f_freeze); end
    n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("FAIL reset.stall got %0d want 0", f_stall); end
    n_cmp++; if (f_ifid !== 1'b0 || f_idexe !== 1'b0) begin n_fail++; $display("FAIL reset.flush got %0d/%0d want 0/0", f_ifid, f_idexe); end
    n_cmp++; if (f_fa !== 2'd0 || f_fb !== 2'd0) begin n_fail++; $display("FAIL reset.fwd got %0d/%0d want 0/0", f_fa, f_fb); end
    n_cmp++; if (f_sc !== 16'd0) begin n_fail++; $display("FAIL reset.stall_cycles got %0d want 0", f_sc); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_fwd_exe();
    clear_in();
    exe_dest = 4'd1; exe_wb_en = 1'b1; id_src1 = 4'd5; id_src2 = 4'd1; id_two_src = 1'b1;
    @(negedge clk);
    n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_exe.stall got %0d want 0", f_stall); end
    next_cycle();
    clear_in();
    @(negedge clk);
    n_cmp++; if (f_fb !== 2'd1) begin n_fail++; $display("FAIL fwd_exe.sel_b got %0d want 1", f_fb); end
    n_cmp++; if (f_fa !== 2'd0) begin n_fail++; $display("FAIL fwd_exe.sel_a got %0d want 0", f_fa); end
    next_cycle();
  endtask

  task automatic test_load_use();
    // preload sel_a=1 so the clear on the bubble is observable
    clear_in();
    exe_dest = 4'd2; exe_wb_en = 1'b1; id_src1 = 4'd2;
    next_cycle();
    exe_mem_r_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (f_fa !== 2'd1) begin n_fail++; $display("FAIL load_use.preload got %0d want 1", f_fa); end
    n_cmp++; if (f_stall !== 1'b1 || f_idexe !== 1'b1) begin n_fail++; $display("FAIL load_use.bubble stall/idexe got %0d/%0d want 1/1", f_stall, f_idexe); end
    n_cmp++; if (f_ifid !== 1'b0) begin n_fail++; $display("FAIL load_use.ifid got %0d want 0", f_ifid); end
    next_cycle();
    clear_in();
    mem_dest = 4'd2; mem_wb_en = 1'b1; id_src1 = 4'd2;
    @(negedge clk);
    n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("FAIL load_use.resume got %0d want 0", f_stall); end
    n_cmp++; if (f_fa !== 2'd0) begin n_fail++; $display("FAIL load_use.cleared got %0d want 0", f_fa); end
    next_cycle();
    clear_in();
    @(negedge clk);
    n_cmp++; if (f_fa !== 2'd2) begin n_fail++; $display("FAIL load_use.sel_wb got %0d want 2", f_fa); end
    n_cmp++; if (f_sc !== 16'd1) begin n_fail++; $display("FAIL load_use.stall_cycles got %0d want 1", f_sc); end
    next_cycle();
  endtask

  task automatic test_stall_only();
    clear_in();
    mem_dest = 4'd3; mem_wb_en = 1'b1; id_src1 = 4'd3;
    @(negedge clk);
    n_cmp++; if (n_stall !== 1'b1 || n_idexe !== 1'b1) begin n_fail++; $display("FAIL stall_only.stall/idexe got %0d/%0d want 1/1", n_stall, n_idexe); end
    n_cmp++; if (n_ifid !== 1'b0) begin n_fail++; $display("FAIL stall_only.ifid got %0d want 0", n_ifid); end
    next_cycle();
    clear_in();
    @(negedge clk);
    n_cmp++; if (n_fa !== 2'd0 || n_fb !== 2'd0) begin n_fail++; $display("FAIL stall_only.fwd got %0d/%0d want 0/0", n_fa, n_fb); end
    next_cycle();
  endtask

  task automatic test_branch();
    clear_in();
    exe_dest = 4'd4; exe_wb_en = 1'b1; id_src1 = 4'd4;
    next_cycle();
    exe_mem_r_en = 1'b1; exe_branch = 1'b1;
    @(negedge clk);
    n_cmp++; if (f_ifid !== 1'b1 || f_idexe !== 1'b1) begin n_fail++; $display("FAIL branch.flush got %0d/%0d want 1/1", f_ifid, f_idexe); end
    n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("FAIL branch.stall got %0d want 0", f_stall); end
    n_cmp++; if (f_fa !== 2'd1) begin n_fail++; $display("FAIL branch.preload got %0d want 1", f_fa); end
    next_cycle();
    clear_in();
    @(negedge clk);
    n_cmp++; if (f_fa !== 2'd0) begin n_fail++; $display("FAIL branch.cleared got %0d want 0", f_fa); end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    // access held throughout; a branch sits in EXE until the release cycle
    clear_in();
    mem_access = 1'b1; exe_branch = 1'b1;
    @(negedge clk);
    n_cmp++; if (f_freeze !== 1'b1) begin n_fail++; $display("FAIL mem_wait.freeze1 got %0d want 1", f_freeze); end
    n_cmp++; if (f_ifid !== 1'b0 || f_stall !== 1'b0) begin n_fail++; $display("FAIL mem_wait.hold1 ifid/stall got %0d/%0d want 0/0", f_ifid, f_stall); end
    n_cmp++; if (n_freeze !== 1'b0) begin n_fail++; $display("FAIL mem_wait.nowait got %0d want 0", n_freeze); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (f_freeze !== 1'b1 || f_ifid !== 1'b0) begin n_fail++; $display("FAIL mem_wait.freeze2 freeze/ifid got %0d/%0d want 1/0", f_freeze, f_ifid); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (f_freeze !== 1'b0) begin n_fail++; $display("FAIL mem_wait.release got %0d want 0", f_freeze); end
    n_cmp++; if (f_ifid !== 1'b1 || f_idexe !== 1'b1) begin n_fail++; $display("FAIL mem_wait.branch flush got %0d/%0d want 1/1", f_ifid, f_idexe); end
    n_cmp++; if (f_sc !== 16'd3) begin n_fail++; $display("FAIL mem_wait.stall_cycles got %0d want 3", f_sc); end
    n_cmp++; if (w_freeze !== 1'b1) begin n_fail++; $display("FAIL mem_wait.w3_freeze3 got %0d want 1", w_freeze); end
    next_cycle();
    exe_branch = 1'b0;
    @(negedge clk);
    n_cmp++; if (f_freeze !== 1'b1) begin n_fail++; $display("FAIL mem_wait.back_to_back got %0d want 1", f_freeze); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    clear_in();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mem_access = 1'b1;
    @(negedge clk);
    n_cmp++; if (w_freeze !== 1'b1) begin n_fail++; $display("FAIL rst_wait.freeze1 got %0d want 1", w_freeze); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (w_freeze !== 1'b1) begin n_fail++; $display("FAIL rst_wait.freeze2 got %0d want 1", w_freeze); end
    n_cmp++; if (w_sc !== 16'd1) begin n_fail++; $display("FAIL rst_wait.count got %0d want 1", w_sc); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mem_access = 1'b0;
    @(negedge clk);
    n_cmp++; if (w_freeze !== 1'b0) begin n_fail++; $display("FAIL rst_wait.freeze got %0d want 0", w_freeze); end
    n_cmp++; if (w_stall !== 1'b0 || w_ifid !== 1'b0 || w_idexe !== 1'b0) begin n_fail++; $display("FAIL rst_wait.ctrl got %0d/%0d/%0d want 0/0/0", w_stall, w_ifid, w_idexe); end
    n_cmp++; if (w_fa !== 2'd0 || w_fb !== 2'd0) begin n_fail++; $display("FAIL rst_wait.fwd got %0d/%0d want 0/0", w_fa, w_fb); end
    n_cmp++; if (w_sc !== 16'd0) begin n_fail++; $display("FAIL rst_wait.stall_cycles got %0d want 0", w_sc); end
    next_cycle();
    mem_access = 1'b1;
    @(negedge clk);
    n_cmp++; if (w_freeze !== 1'b1) begin n_fail++; $display("FAIL rst_wait.restart got %0d want 1", w_freeze); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    next_cycle();
    test_reset();
    test_fwd_exe();
    test_load_use();
    test_stall_only();
    test_branch();
    test_mem_wait();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
